// File: rtl/simplecore_pkg.sv
// Shared constants for the simplecore memory-write path: FSM state codes
// and the default STROBE timeout used by dout_arbiter.
package simplecore_pkg;

  // Write-sequencer states, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Width of the STROBE cycle counter; TIMEOUT must fit in it.
  localparam int CNT_W = 4;

  // Default maximum number of STROBE cycles before the write is abandoned.
  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. The requester that was not granted last
// wins a tie; a lone requester always wins. Grant is one-hot (bit 0 = port 0).
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Tie goes to the port opposite last_grant.
  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dout_arbiter.sv
// Arbitrates core and I/O-DMA store requests onto a single memory write
// port. Each grant runs IDLE(capture) -> SETUP -> STROBE -> HOLD; the
// winner gets a one-cycle ack in HOLD unless the strobe timed out.
module dout_arbiter
  import simplecore_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic [15:0] data1,
  output logic        ack1,
  input  logic        memRdy,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] dOut,
  output logic        busy
);

  // Timeout compared against count+1, so one extra bit avoids wrap at 15.
  localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             abort_q, abort_d;
  logic             last_q, last_d;   // 1 = port 1 was granted last
  logic             gnt_q, gnt_d;     // port owning the current transfer
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [1:0]       grant;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Next-state logic: capture on grant, count strobe cycles, flag timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          gnt_d   = grant[1];
          last_d  = grant[1];
          addr_d  = grant[1] ? addr1 : addr0;
          data_d  = grant[1] ? data1 : data0;
          abort_d = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        // cnt_q holds the number of strobe cycles already completed.
        cnt_d = cnt_inc[CNT_W-1:0];
        if (memRdy) begin
          state_d = ST_HOLD;
        end else if (cnt_inc == TIMEOUT_V) begin
          state_d = ST_HOLD;
          abort_d = 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode straight from registered state.
  always_comb begin
    memWr   = (state_q == ST_STROBE);
    busy    = (state_q != ST_IDLE);
    ack0    = (state_q == ST_HOLD) && !abort_q && !gnt_q;
    ack1    = (state_q == ST_HOLD) && !abort_q && gnt_q;
    memAddr = addr_q;
    dOut    = data_q;
  end

endmodule

// File: tb/tb_dout_arbiter.sv
// Randomized and directed bench for dout_arbiter. The reference model
// tracks each transfer by its start cycle and strobe length and derives
// every expected output from that timeline.
module tb_dout_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, ack0, ack1;
  logic [15:0] addr0, data0, addr1, data1;
  logic        memRdy, memWr, busy;
  logic [15:0] memAddr, dOut;

  dout_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .addr0   (addr0),
    .data0   (data0),
    .ack0    (ack0),
    .req1    (req1),
    .addr1   (addr1),
    .data1   (data1),
    .ack1    (ack1),
    .memRdy  (memRdy),
    .memWr   (memWr),
    .memAddr (memAddr),
    .dOut    (dOut),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: one transfer described by start cycle and lengths.
  bit          active = 1'b0;
  int          t0 = 0, s_len = 0, lat = 0;
  bit          ab = 1'b0, win = 1'b0, last_g = 1'b1;
  logic [15:0] e_addr = '0, e_data = '0;
  int          n_xfer = 0;

  // Requester agents and stimulus knobs.
  bit          pend[2];
  bit          ack_prev[2];
  logic [15:0] a_val[2], d_val[2];
  int          raise_pct = 0, keep_pct = 0, chg_pct = 0;
  int          fixed_lat = 0, rst_at = -1, rst_rate = 0;

  // Observations of the DUT for scenario-level checks.
  int wr_cnt = 0, ack_cnt = 0, ack_cyc = -1;
  int order[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic new_vals(input int p);
    a_val[p] = 16'($urandom);
    d_val[p] = 16'($urandom);
  endtask

  function automatic bit model_busy();
    return active && (cyc < t0 + 3 + s_len);
  endfunction

  // One clock cycle: check outputs, advance agents, drive inputs, update model.
  task automatic step();
    bit e_busy, e_wr, e_ack, in_strobe;
    e_busy    = active && (cyc >= t0 + 1) && (cyc <= t0 + 2 + s_len);
    e_wr      = active && (cyc >= t0 + 2) && (cyc <= t0 + 1 + s_len);
    e_ack     = active && !ab && (cyc == t0 + 2 + s_len);
    in_strobe = e_wr;

    check_val("busy", busy, e_busy);
    check_val("memWr", memWr, e_wr);
    check_val("ack0", ack0, e_ack && !win);
    check_val("ack1", ack1, e_ack && win);
    check_val("memAddr", memAddr, e_addr);
    check_val("dOut", dOut, e_data);
    check_val("ack_excl", ack0 & ack1, 1'b0);

    wr_cnt += int'(memWr);
    if (ack0 || ack1) begin
      ack_cnt++;
      ack_cyc = cyc;
      order.push_back(ack1 ? 1 : 0);
    end
    if (active && cyc == t0 + 2 + s_len)
      $display("xfer %0d: port=%0d addr=%04h data=%04h strobe=%0d %s",
               n_xfer, win, e_addr, e_data, s_len, ab ? "aborted" : "acked");

    for (int p = 0; p < 2; p++) begin
      if (ack_prev[p]) begin
        pend[p] = ($urandom_range(99) < keep_pct);
        if (pend[p]) new_vals(p);
      end else if (!pend[p]) begin
        if ($urandom_range(99) < raise_pct) begin
          pend[p] = 1'b1;
          new_vals(p);
        end
      end else if ($urandom_range(99) < chg_pct) begin
        new_vals(p);
      end
      ack_prev[p] = e_ack && (int'(win) == p);
    end

    req0  = pend[0];
    addr0 = a_val[0];
    data0 = d_val[0];
    req1  = pend[1];
    addr1 = a_val[1];
    data1 = d_val[1];
    if (in_strobe) memRdy = (cyc == t0 + 2 + lat);
    else           memRdy = 1'($urandom_range(1));
    reset = (cyc == rst_at) || ($urandom_range(999) < rst_rate);

    if (reset) begin
      active = 1'b0;
      e_addr = '0;
      e_data = '0;
      last_g = 1'b1;
    end else if (!model_busy() && (pend[0] || pend[1])) begin
      // Tie goes to whoever was not granted last.
      win    = (pend[0] && pend[1]) ? !last_g : pend[1];
      last_g = win;
      active = 1'b1;
      t0     = cyc;
      if (fixed_lat >= 0) lat = fixed_lat;
      else lat = ($urandom_range(7) == 0) ? int'($urandom_range(18, 14)) : int'($urandom_range(4));
      s_len  = (lat < TIMEOUT) ? lat + 1 : TIMEOUT;
      ab     = (lat >= TIMEOUT);
      e_addr = a_val[win];
      e_data = d_val[win];
      n_xfer++;
    end

    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend[0] || pend[1] || model_busy()) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check_val("drain_timeout", 1, 0);
  endtask

  task automatic clear_obs();
    wr_cnt  = 0;
    ack_cnt = 0;
    ack_cyc = -1;
    order.delete();
  endtask

  initial begin
    int start, n;
    logic [15:0] cap;
    reset = 1'b1;
    {req0, req1, memRdy} = '0;
    {addr0, data0, addr1, data1} = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; ack_prev[p] = 1'b0; a_val[p] = '0; d_val[p] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state is checked in the first step.
    rst_at = 0;
    step();
    rst_at = -1;

    // Single core write with immediate memRdy.
    clear_obs();
    pend[0] = 1'b1; a_val[0] = 16'h0010; d_val[0] = 16'hBEEF; fixed_lat = 0;
    start = cyc;
    drain();
    check_val("s1_wr_cycles", wr_cnt, 1);
    check_val("s1_ack_cnt", ack_cnt, 1);
    check_val("s1_ack_cycle", ack_cyc - start, 3);
    check_val("s1_memAddr", memAddr, 16'h0010);
    check_val("s1_dOut", dOut, 16'hBEEF);

    // Both requesters held after reset: strict alternation.
    rst_at = cyc;
    step();
    rst_at = -1;
    clear_obs();
    pend[0] = 1'b1; pend[1] = 1'b1; new_vals(0); new_vals(1); keep_pct = 100;
    n = 0;
    while (order.size() < 4 && n < 100) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++)
      check_val("s2_order", (i < order.size()) ? order[i] : 2, i % 2);
    keep_pct = 0;
    drain();

    // DMA write with memRdy low for 3 strobe cycles.
    clear_obs();
    pend[1] = 1'b1; new_vals(1); fixed_lat = 3;
    drain();
    check_val("s3_wr_cycles", wr_cnt, 4);
    check_val("s3_ack_cnt", ack_cnt, 1);
    check_val("s3_dOut", dOut, d_val[1]);

    // Timeout: memRdy never comes, no ack, then the next request is served.
    clear_obs();
    pend[0] = 1'b1; new_vals(0); fixed_lat = 20;
    repeat (18) step();
    pend[0] = 1'b0;
    check_val("s4_wr_cycles", wr_cnt, TIMEOUT);
    check_val("s4_abort_ack", ack_cnt, 0);
    pend[1] = 1'b1; new_vals(1); fixed_lat = 0;
    drain();
    check_val("s4_next_ack", ack_cnt, 1);
    check_val("s4_next_dOut", dOut, d_val[1]);

    // Reset during STROBE abandons the transfer.
    clear_obs();
    pend[0] = 1'b1; new_vals(0); fixed_lat = 10;
    repeat (4) step();
    rst_at = cyc;
    step();
    rst_at = -1;
    check_val("s5_memWr", memWr, 1'b0);
    check_val("s5_busy", busy, 1'b0);
    check_val("s5_dOut", dOut, 16'h0000);
    check_val("s5_no_ack", ack_cnt, 0);
    fixed_lat = 0;
    drain();

    // Data changing after capture must not disturb dOut.
    pend[0] = 1'b1; new_vals(0); fixed_lat = 5;
    step();
    cap = d_val[0];
    chg_pct = 100;
    repeat (5) step();
    check_val("s6_dOut_mid", dOut, cap);
    chg_pct = 0;
    drain();
    check_val("s6_dOut_end", dOut, cap);

    // Randomized traffic with occasional resets.
    raise_pct = 30; keep_pct = 50; chg_pct = 20; fixed_lat = -1; rst_rate = 3;
    repeat (3000) step();
    raise_pct = 0; keep_pct = 0; chg_pct = 0; rst_rate = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
